// File: rtl/ace_pkg.sv
// Shared ACE snoop types: AC snoop opcodes, decoder snoop info, CRRESP bit map and
// the merged snoop result handed back to the CCU read path.
package ace_pkg;

    typedef logic [3:0] acsnoop_t;

    localparam acsnoop_t ReadOnce           = 4'b0000;
    localparam acsnoop_t ReadShared         = 4'b0001;
    localparam acsnoop_t ReadClean          = 4'b0010;
    localparam acsnoop_t ReadNotSharedDirty = 4'b0011;
    localparam acsnoop_t ReadUnique         = 4'b0111;
    localparam acsnoop_t CleanShared        = 4'b1000;
    localparam acsnoop_t CleanInvalid       = 4'b1001;
    localparam acsnoop_t MakeInvalid        = 4'b1101;

    typedef struct packed {
        acsnoop_t snoop_trs;
        logic     accepts_dirty;
        logic     excl_load;
        logic     excl_store;
    } snoop_info_t;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    // Fixed-width source index so the struct does not depend on NumMasters.
    localparam int unsigned SrcWidth = 8;

    typedef struct packed {
        logic                data_transfer;
        logic                error;
        logic                pass_dirty;
        logic                is_shared;
        logic                was_unique;
        logic [SrcWidth-1:0] data_src;
        logic                needs_wb;
        logic                illegal;
        logic                snooped;
        logic                excl_load;
        logic                excl_store;
    } snoop_rsp_t;

endpackage

// File: rtl/ace_snoop_resp_merge.sv
// Combinational merge of one cycle's accepted CR responses into the running
// accumulator, plus lowest-index selection of the data-providing master.
module ace_snoop_resp_merge
    import ace_pkg::*;
#(
    parameter int unsigned NumMasters = 4,
    parameter int unsigned IdxWidth   = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic [4:0]              acc_flags,
    input  logic [NumMasters-1:0]   acc_dt,
    input  logic [NumMasters-1:0]   hs,
    input  logic [5*NumMasters-1:0] cr_resp,
    output logic [4:0]              flags,
    output logic [NumMasters-1:0]   dt,
    output logic [IdxWidth-1:0]     src
);

    always_comb begin
        flags = acc_flags;
        dt    = acc_dt;
        src   = '0;
        for (int m = 0; m < NumMasters; m++) begin
            if (hs[m]) begin
                flags = flags | cr_resp[5*m +: 5];
                dt[m] = dt[m] | cr_resp[5*m + CrDataTransfer];
            end
        end
        // Descending scan so the lowest set index is the last one written.
        for (int m = NumMasters - 1; m >= 0; m--) begin
            if (dt[m]) src = IdxWidth'(m);
        end
    end

endmodule

// File: rtl/ace_snoop_dispatcher.sv
// Broadcasts one decoded read's AC snoop to all non-initiating masters, collects
// their CR responses and returns a single merged result. One transaction at a time.
module ace_snoop_dispatcher
    import ace_pkg::*;
#(
    parameter int unsigned NumMasters = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdxWidth   = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [IdxWidth-1:0]     req_init_i,
    input  logic                    req_snooping_i,
    input  logic                    req_illegal_i,
    input  snoop_info_t             req_info_i,
    output logic [NumMasters-1:0]   ac_valid_o,
    input  logic [NumMasters-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]    ac_addr_o,
    output acsnoop_t                ac_snoop_o,
    input  logic [NumMasters-1:0]   cr_valid_i,
    output logic [NumMasters-1:0]   cr_ready_o,
    input  logic [5*NumMasters-1:0] cr_resp_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output snoop_rsp_t              rsp_o
);

    typedef enum logic [1:0] {Idle, Snoop, Resp} state_e;

    state_e                state, state_next;
    logic [AddrWidth-1:0]  addr;
    snoop_info_t           info;
    logic                  illegal, snooped;
    logic [NumMasters-1:0] ac_pend, cr_pend, dt;
    logic [4:0]            flags;
    logic [IdxWidth-1:0]   src;

    logic [NumMasters-1:0] target, ac_hs, cr_hs, m_dt;
    logic [4:0]            m_flags;
    logic [IdxWidth-1:0]   m_src;
    logic                  accept, go_snoop;

    always_comb begin
        target = '0;
        for (int m = 0; m < NumMasters; m++) target[m] = (req_init_i != IdxWidth'(m));
    end

    assign req_ready_o = (state == Idle);
    assign accept      = req_valid_i && req_ready_o;
    assign go_snoop    = !req_illegal_i && req_snooping_i && (target != '0);

    // A master's CR is only taken once its own AC has been handshaken.
    assign ac_valid_o = ac_pend;
    assign cr_ready_o = cr_pend & ~ac_pend;
    assign ac_hs      = ac_valid_o & ac_ready_i;
    assign cr_hs      = cr_ready_o & cr_valid_i;
    assign ac_addr_o  = addr;
    assign ac_snoop_o = info.snoop_trs;

    ace_snoop_resp_merge #(
        .NumMasters (NumMasters),
        .IdxWidth   (IdxWidth)
    ) u_merge (
        .acc_flags (flags),
        .acc_dt    (dt),
        .hs        (cr_hs),
        .cr_resp   (cr_resp_i),
        .flags     (m_flags),
        .dt        (m_dt),
        .src       (m_src)
    );

    always_comb begin
        state_next = state;
        case (state)
            Idle:  if (accept) state_next = go_snoop ? Snoop : Resp;
            Snoop: if (cr_pend == '0) state_next = Resp;
            Resp:  if (rsp_ready_i) state_next = Idle;
            default: state_next = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= Idle;
            addr    <= '0;
            info    <= '0;
            illegal <= 1'b0;
            snooped <= 1'b0;
            ac_pend <= '0;
            cr_pend <= '0;
            flags   <= '0;
            dt      <= '0;
            src     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr    <= req_addr_i;
                info    <= req_info_i;
                illegal <= req_illegal_i;
                snooped <= go_snoop;
                ac_pend <= go_snoop ? target : '0;
                cr_pend <= go_snoop ? target : '0;
                flags   <= '0;
                dt      <= '0;
                src     <= '0;
            end else if (state == Snoop) begin
                ac_pend <= ac_pend & ~ac_hs;
                cr_pend <= cr_pend & ~cr_hs;
                flags   <= m_flags;
                dt      <= m_dt;
                src     <= m_src;
            end
        end
    end

    assign rsp_valid_o = (state == Resp);

    always_comb begin
        rsp_o = '0;
        if (state == Resp) begin
            rsp_o.data_transfer = flags[CrDataTransfer];
            rsp_o.error         = flags[CrError];
            rsp_o.pass_dirty    = flags[CrPassDirty];
            rsp_o.is_shared     = flags[CrIsShared];
            rsp_o.was_unique    = flags[CrWasUnique];
            rsp_o.data_src      = flags[CrDataTransfer] ? SrcWidth'(src) : '0;
            rsp_o.needs_wb      = flags[CrPassDirty] & ~info.accepts_dirty;
            rsp_o.illegal       = illegal;
            rsp_o.snooped       = snooped;
            rsp_o.excl_load     = info.excl_load;
            rsp_o.excl_store    = info.excl_store;
        end
    end

endmodule

// File: tb/tb_ace_snoop_dispatcher.sv
// Directed bench for ace_snoop_dispatcher with four masters: bypass paths, merged
// responses, staggered handshakes, result backpressure and mid-snoop reset.
module tb_ace_snoop_dispatcher;
    import ace_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_init = '0;
    logic        req_snooping = 1'b0;
    logic        req_illegal = 1'b0;
    snoop_info_t req_info = '0;
    logic [3:0]  ac_valid;
    logic [3:0]  ac_ready = '0;
    logic [63:0] ac_addr;
    acsnoop_t    ac_snoop;
    logic [3:0]  cr_valid = '0;
    logic [3:0]  cr_ready;
    logic [19:0] cr_resp = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    snoop_rsp_t  rsp;
    snoop_rsp_t  exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ace_snoop_dispatcher #(.NumMasters(4), .AddrWidth(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_init_i(req_init), .req_snooping_i(req_snooping), .req_illegal_i(req_illegal),
        .req_info_i(req_info),
        .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr), .ac_snoop_o(ac_snoop),
        .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; the DUT is idle so it is accepted.
    task automatic send_req(input logic [63:0] a, input logic [1:0] init, input logic snp,
                            input logic ill, input snoop_info_t inf);
        req_addr = a; req_init = init; req_snooping = snp; req_illegal = ill; req_info = inf;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (ac_valid !== 4'b0) begin errors++; $display("FAIL reset_ac_valid got %b exp 0000", ac_valid); end
        checks++; if (cr_ready !== 4'b0) begin errors++; $display("FAIL reset_cr_ready got %b exp 0000", cr_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp !== snoop_rsp_t'('0)) begin errors++; $display("FAIL reset_rsp got %h exp 0", rsp); end
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_broadcast();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = ReadShared; inf.accepts_dirty = 1'b1;
        ac_ready = 4'b1111; cr_valid = 4'b1111; cr_resp = '0;
        send_req(64'hDEAD_BEEF_0000_1040, 2'd0, 1'b1, 1'b0, inf);
        checks++; if (ac_valid !== 4'b1110) begin errors++; $display("FAIL bc_ac_valid got %b exp 1110", ac_valid); end
        checks++; if (ac_addr !== 64'hDEAD_BEEF_0000_1040) begin errors++; $display("FAIL bc_ac_addr got %h exp deadbeef00001040", ac_addr); end
        checks++; if (ac_snoop !== ReadShared) begin errors++; $display("FAIL bc_ac_snoop got %h exp %h", ac_snoop, ReadShared); end
        checks++; if (cr_ready !== 4'b0000) begin errors++; $display("FAIL bc_cr_ready_early got %b exp 0000", cr_ready); end
        tick();
        checks++; if (cr_ready !== 4'b1110) begin errors++; $display("FAIL bc_cr_ready got %b exp 1110", cr_ready); end
        checks++; if (ac_valid !== 4'b0000) begin errors++; $display("FAIL bc_ac_done got %b exp 0000", ac_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bc_rsp_early got %b exp 0", rsp_valid); end
        tick();
        exp = '0; exp.snooped = 1'b1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bc_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp !== exp) begin errors++; $display("FAIL bc_rsp got %h exp %h", rsp, exp); end
        ac_ready = '0; cr_valid = '0;
        finish_rsp();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bc_back_idle got %b exp 1", req_ready); end
    endtask

    task automatic test_dirty_merge();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = ReadShared; inf.accepts_dirty = 1'b0;
        ac_ready = 4'b1111; cr_valid = 4'b1111;
        cr_resp = {5'b00000, 5'b00000, 5'b00101, 5'b00000};
        send_req(64'h80, 2'd2, 1'b1, 1'b0, inf);
        checks++; if (ac_valid !== 4'b1011) begin errors++; $display("FAIL dm_ac_valid got %b exp 1011", ac_valid); end
        tick(); tick(); tick();
        exp = '0; exp.data_transfer = 1'b1; exp.pass_dirty = 1'b1; exp.data_src = 8'd1;
        exp.needs_wb = 1'b1; exp.snooped = 1'b1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dm_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp !== exp) begin errors++; $display("FAIL dm_rsp got %h exp %h", rsp, exp); end
        ac_ready = '0; cr_valid = '0; cr_resp = '0;
        finish_rsp();
    endtask

    task automatic test_no_snoop();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = ReadOnce; inf.excl_load = 1'b1;
        send_req(64'h100, 2'd1, 1'b0, 1'b0, inf);
        exp = '0; exp.excl_load = 1'b1;
        checks++; if (ac_valid !== 4'b0) begin errors++; $display("FAIL ns_ac_valid got %b exp 0000", ac_valid); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ns_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp !== exp) begin errors++; $display("FAIL ns_rsp got %h exp %h", rsp, exp); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = ReadUnique;
        cr_valid = 4'b1111; cr_resp = {4{5'b11111}};
        send_req(64'h140, 2'd3, 1'b1, 1'b1, inf);
        exp = '0; exp.illegal = 1'b1;
        checks++; if (ac_valid !== 4'b0) begin errors++; $display("FAIL il_ac_valid got %b exp 0000", ac_valid); end
        checks++; if (cr_ready !== 4'b0) begin errors++; $display("FAIL il_cr_ready got %b exp 0000", cr_ready); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL il_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp !== exp) begin errors++; $display("FAIL il_rsp got %h exp %h", rsp, exp); end
        cr_valid = '0; cr_resp = '0;
        finish_rsp();
    endtask

    task automatic test_staggered();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = ReadClean; inf.accepts_dirty = 1'b1;
        send_req(64'h200, 2'd0, 1'b1, 1'b0, inf);
        ac_ready = 4'b0110; cr_valid = 4'b0010;
        cr_resp = {5'b10001, 5'b00001, 5'b01000, 5'b00000};
        checks++; if (ac_valid !== 4'b1110) begin errors++; $display("FAIL st_ac_valid got %b exp 1110", ac_valid); end
        tick();
        checks++; if (cr_ready !== 4'b0110) begin errors++; $display("FAIL st_cr_ready got %b exp 0110", cr_ready); end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (ac_valid !== 4'b1000 || cr_ready !== 4'b0100) begin
                errors++; $display("FAIL st_hold[%0d] ac_valid %b cr_ready %b exp 1000 0100", i, ac_valid, cr_ready);
            end
            tick();
        end
        ac_ready = 4'b1000; cr_valid = 4'b1100;
        tick();
        checks++; if (cr_ready !== 4'b1000) begin errors++; $display("FAIL st_cr_ready_m3 got %b exp 1000", cr_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL st_rsp_early got %b exp 0", rsp_valid); end
        ac_ready = '0; cr_valid = '0;
        tick();
        exp = '0; exp.data_transfer = 1'b1; exp.is_shared = 1'b1; exp.was_unique = 1'b1;
        exp.data_src = 8'd2; exp.snooped = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp !== exp || req_ready !== 1'b0) begin
                errors++; $display("FAIL st_stall[%0d] valid %b rsp %h req_ready %b exp 1 %h 0", i, rsp_valid, rsp, req_ready, exp);
            end
            tick();
        end
        cr_resp = '0;
        finish_rsp();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL st_release req_ready %b rsp_valid %b exp 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_mid_reset();
        snoop_info_t inf;
        inf = '0; inf.snoop_trs = CleanShared;
        ac_ready = '0;
        send_req(64'h300, 2'd1, 1'b1, 1'b0, inf);
        tick(); tick();
        checks++; if (ac_valid !== 4'b1101) begin errors++; $display("FAIL mr_ac_hold got %b exp 1101", ac_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ac_valid !== 4'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || cr_ready !== 4'b0) begin
            errors++; $display("FAIL mr_after_reset ac %b rsp_valid %b req_ready %b cr %b exp 0000 0 1 0000", ac_valid, rsp_valid, req_ready, cr_ready);
        end
        inf = '0; inf.snoop_trs = ReadShared; inf.accepts_dirty = 1'b1;
        ac_ready = 4'b1111; cr_valid = 4'b1111;
        cr_resp = {5'b00000, 5'b00000, 5'b00000, 5'b00001};
        send_req(64'h340, 2'd3, 1'b1, 1'b0, inf);
        checks++; if (ac_valid !== 4'b0111) begin errors++; $display("FAIL mr_new_ac got %b exp 0111", ac_valid); end
        tick(); tick(); tick();
        exp = '0; exp.data_transfer = 1'b1; exp.data_src = 8'd0; exp.snooped = 1'b1;
        checks++; if (rsp_valid !== 1'b1 || rsp !== exp) begin
            errors++; $display("FAIL mr_new_rsp valid %b rsp %h exp 1 %h", rsp_valid, rsp, exp);
        end
        ac_ready = '0; cr_valid = '0; cr_resp = '0;
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_dirty_merge();
        test_no_snoop();
        test_illegal();
        test_staggered();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
